fb_scanout_reader: RTL and testbench

//  Display-side reader of the on-chip framebuffer (OCM) filled by the background loader.

---
 rtl/fb_pkg.sv | 22 ++
 rtl/fb_scanout_reader_if.sv | 14 +
 rtl/fb_word_fifo.sv | 54 +++++
 rtl/fb_scanout_reader.sv | 132 +++++++++++++
 tb/tb_fb_scanout_reader.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer scan-out reader.
package fb_pkg;

  localparam int FB_WORDS   = 153600;  // 640*480 pixels, two pixels per word
  localparam int OCM_ADDR_W = 19;
  localparam int RD_LAT     = 2;       // fixed OCM read latency after a grant

  typedef logic [7:0]            pixel_t;
  typedef logic [15:0]           fb_word_t;
  typedef logic [OCM_ADDR_W-1:0] ocm_addr_t;

  typedef enum logic [1:0] {IDLE, FLUSH, FILL, RUN} scan_state_e;

  // The high byte of each word is the earlier pixel on the line
  localparam logic BYTE_HI = 1'b0;
  localparam logic BYTE_LO = 1'b1;

  function automatic pixel_t pick_byte(input fb_word_t word, input logic sel);
    return (sel == BYTE_HI) ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/fb_scanout_reader_if.sv
// Arbitrated OCM read port: the reader is the master, the OCM/arbiter the slave.
interface fb_scanout_reader_if;
  import fb_pkg::*;

  logic      rd_req;
  ocm_addr_t rd_addr;
  logic      rd_gnt;
  logic      rd_valid;
  fb_word_t  rd_data;

  modport master (output rd_req, rd_addr, input rd_gnt, rd_valid, rd_data);
  modport slave  (input rd_req, rd_addr, output rd_gnt, rd_valid, rd_data);

endinterface

// File: rtl/fb_word_fifo.sv
// Synchronous word FIFO with show-ahead head; DEPTH must be a power of two.
module fb_word_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  fb_word_t                 din,
  output fb_word_t                 head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  fb_word_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  // Storage array carries data only, so it is not reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; clear empties the FIFO in one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
  no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/fb_scanout_reader.sv
// Framebuffer scan-out reader: fetches OCM words in raster order into a small
// FIFO and hands out one 8-bit pixel per consumer request.
// Optional build macro FB_SCANOUT_STATS_EN adds a saturating underflow counter.
module fb_scanout_reader
  import fb_pkg::*;
#(
  parameter int FB_WORDS   = fb_pkg::FB_WORDS,
  parameter int FIFO_DEPTH = 8
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   frame_start,
  input  logic   pix_req,
  output pixel_t pix_data,
  output logic   pix_valid,
  output logic   underflow,
`ifdef FB_SCANOUT_STATS_EN
  output logic [15:0] underflow_cnt,
`endif
  fb_scanout_reader_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < RD_LAT + 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least RD_LAT+2");
  end

  scan_state_e state;
  ocm_addr_t   addr;
  logic [CW:0] inflight;
  logic [CW:0] count;
  logic        full;
  logic        empty;
  fb_word_t    head;
  logic        byte_sel;

  logic          fetching;
  logic [CW+1:0] occupancy;
  logic          xfer;
  logic          ret;
  logic          push;
  logic          serve;
  logic          starve;
  logic          pop;

  // Request gating counts words already in flight so the FIFO can never overflow
  assign fetching    = (state == FILL) || (state == RUN);
  assign occupancy   = {1'b0, count} + {1'b0, inflight};
  assign bus.rd_req  = fetching && (addr < OCM_ADDR_W'(FB_WORDS)) &&
                       (occupancy < (CW+2)'(FIFO_DEPTH));
  assign bus.rd_addr = addr;
  assign xfer        = bus.rd_req && bus.rd_gnt;
  // A return with nothing outstanding (e.g. issued before a reset) is ignored;
  // returns during a frame restart are counted off but never stored
  assign ret         = bus.rd_valid && (inflight != '0);
  assign push        = ret && fetching && !frame_start;
  assign serve       = fetching && !frame_start && pix_req && !empty;
  assign starve      = fetching && !frame_start && pix_req && empty;
  assign pop         = serve && (byte_sel == BYTE_LO);

  fb_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (frame_start),
    .push  (push),
    .pop   (pop),
    .din   (bus.rd_data),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Scan state: frame_start always restarts via FLUSH, which drains old reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (frame_start) begin
      state <= FLUSH;
    end else begin
      case (state)
        FLUSH:   if (inflight == '0) state <= FILL;
        FILL:    if (full || addr == OCM_ADDR_W'(FB_WORDS)) state <= RUN;
        default: state <= state;
      endcase
    end
  end

  // Fetch address and outstanding-read count; address parks at FB_WORDS
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr     <= '0;
      inflight <= '0;
    end else begin
      if (frame_start) addr <= '0;
      else if (xfer)   addr <= addr + OCM_ADDR_W'(1);
      inflight <= inflight + {{CW{1'b0}}, xfer} - {{CW{1'b0}}, ret};
    end
  end

  // Pixel output register, byte alternation and sticky underflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_data  <= '0;
      pix_valid <= 1'b0;
      underflow <= 1'b0;
      byte_sel  <= BYTE_HI;
    end else begin
      pix_valid <= serve;
      if (frame_start) begin
        byte_sel  <= BYTE_HI;
        underflow <= 1'b0;
      end else if (serve) begin
        pix_data <= pick_byte(head, byte_sel);
        byte_sel <= ~byte_sel;
      end else if (starve) begin
        pix_data  <= '0;
        underflow <= 1'b1;
      end
    end
  end

`ifdef FB_SCANOUT_STATS_EN
  // Saturating count of starved pixel requests, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   underflow_cnt <= '0;
    else if (starve && underflow_cnt != '1)    underflow_cnt <= underflow_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fb_scanout_reader.sv
// Scoreboard bench for fb_scanout_reader with a small frame and an OCM model.
module tb_fb_scanout_reader;

  localparam int FBW = 24;   // 48 pixels per test frame

  typedef struct packed {
    logic       v;    // pix_valid expected
    logic       cd;   // check pix_data
    logic [7:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic frame_start;
  logic pix_req;
  logic [7:0] pix_data;
  logic pix_valid;
  logic underflow;
`ifdef FB_SCANOUT_STATS_EN
  logic [15:0] underflow_cnt;
`endif

  fb_scanout_reader_if bus ();

  fb_scanout_reader #(.FB_WORDS(FBW), .FIFO_DEPTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .pix_req     (pix_req),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .underflow   (underflow),
`ifdef FB_SCANOUT_STATS_EN
    .underflow_cnt (underflow_cnt),
`endif
    .bus         (bus.master)
  );

  always #5 clk = ~clk;

  int   n_vec  = 0;
  int   n_miss = 0;
  exp_t sb[$];

  // OCM word n = {~n[7:0], n[7:0]} so both bytes identify the word
  function automatic logic [15:0] word_of(input logic [18:0] a);
    return {~a[7:0], a[7:0]};
  endfunction

  function automatic logic [7:0] exp_pix(input int k);
    logic [15:0] w;
    w = word_of(19'(k >> 1));
    return k[0] ? w[7:0] : w[15:8];
  endfunction

  // OCM model: fixed two-cycle latency, not reset by the DUT reset
  logic        v1 = 1'b0, v2 = 1'b0;
  logic [18:0] a1 = '0;
  logic [15:0] d2 = '0;
  always @(posedge clk) begin
    v1 <= bus.rd_req && bus.rd_gnt;
    a1 <= bus.rd_addr;
    v2 <= v1;
    d2 <= word_of(a1);
  end
  assign bus.rd_valid = v2;
  assign bus.rd_data  = d2;

  // Monitor: every cycle that carried pix_req is compared with the queue head
  logic mon_req;
  exp_t mon_e;
  always @(posedge clk) begin
    mon_req = pix_req;
    #1;
    if (mon_req) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_miss++;
        $display("FAIL sb_extra: pixel response with no expectation, valid=%0b data=%02h", pix_valid, pix_data);
      end else begin
        mon_e = sb.pop_front();
        if (pix_valid !== mon_e.v || (mon_e.cd && pix_data !== mon_e.d)) begin
          n_miss++;
          $display("FAIL pixel: got valid=%0b data=%02h, want valid=%0b data=%02h%s",
                   pix_valid, pix_data, mon_e.v, mon_e.d, mon_e.cd ? "" : " (data not checked)");
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_req(input logic v, input logic cd, input logic [7:0] d);
    exp_t e;
    e.v = v; e.cd = cd; e.d = d;
    pix_req = 1'b1;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    pix_req = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b1; frame_start = 1'b0; pix_req = 1'b0; bus.rd_gnt = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pix_valid", 32'(pix_valid), 0);
    chk("rst_pix_data",  32'(pix_data), 0);
    chk("rst_underflow", 32'(underflow), 0);
    chk("rst_rd_req",    32'(bus.rd_req), 0);
    chk("rst_rd_addr",   32'(bus.rd_addr), 0);
`ifdef FB_SCANOUT_STATS_EN
    chk("rst_cnt",       32'(underflow_cnt), 0);
`endif
    rst = 1'b0;
    bus.rd_gnt = 1'b1;

    // IDLE ignores requests and issues no reads
    for (int i = 0; i < 3; i++) do_req(1'b0, 1'b1, 8'h00);
    pix_req = 1'b0;
    chk("idle_rd_req", 32'(bus.rd_req), 0);

    // Starvation: fill, cut the grant, drain 16 pixels then underflow
    frame();
    idle(20);
    chk("fill_addr", 32'(bus.rd_addr), 8);
    bus.rd_gnt = 1'b0;
    for (int i = 0; i < 16; i++) do_req(1'b1, 1'b1, exp_pix(i));
    do_req(1'b0, 1'b1, 8'h00);
    pix_req = 1'b0;
    chk("starve_underflow", 32'(underflow), 1);
`ifdef FB_SCANOUT_STATS_EN
    chk("starve_cnt1", 32'(underflow_cnt), 1);
`endif
    do_req(1'b0, 1'b1, 8'h00);
    pix_req = 1'b0;
`ifdef FB_SCANOUT_STATS_EN
    chk("starve_cnt2", 32'(underflow_cnt), 2);
`endif
    // Byte alignment survives the underflow
    bus.rd_gnt = 1'b1;
    idle(12);
    for (int i = 16; i < 20; i++) do_req(1'b1, 1'b1, exp_pix(i));
    idle(2);

    // Full frame, continuous consumer, then one request past the end
    frame();
    idle(20);
    for (int i = 0; i < 2*FBW; i++) do_req(1'b1, 1'b1, exp_pix(i));
    pix_req = 1'b0;
    chk("frame_underflow", 32'(underflow), 0);
    chk("frame_end_addr",  32'(bus.rd_addr), FBW);
    do_req(1'b0, 1'b1, 8'h00);
    pix_req = 1'b0;
    chk("past_end_underflow", 32'(underflow), 1);

    // Grant gap of 20 cycles with a slow consumer
    frame();
    idle(20);
    k = 0;
    for (int i = 0; i < 96; i++) begin
      bus.rd_gnt = (i < 20 || i >= 40);
      if (i % 4 == 0) begin
        do_req(1'b1, 1'b1, exp_pix(k));
        k++;
      end else begin
        idle(1);
      end
    end
    pix_req = 1'b0;
    bus.rd_gnt = 1'b1;
    chk("stall_underflow", 32'(underflow), 0);

    // Restart with two reads in flight, pix_req coincident with frame_start
    bus.rd_gnt = 1'b0;
    idle(4);
    frame();
    @(negedge clk);
    bus.rd_gnt = 1'b1;
    repeat (2) @(negedge clk);
    bus.rd_gnt = 1'b0;
    frame_start = 1'b1;
    do_req(1'b0, 1'b0, 8'h00);
    frame_start = 1'b0;
    pix_req = 1'b0;
    chk("restart_underflow", 32'(underflow), 0);
    chk("flush_rd_req", 32'(bus.rd_req), 0);
    bus.rd_gnt = 1'b1;
    idle(15);
    for (int i = 0; i < 4; i++) do_req(1'b1, 1'b1, exp_pix(i));
    pix_req = 1'b0;

    // Asynchronous reset mid-RUN
    frame();
    idle(15);
    for (int i = 0; i < 3; i++) do_req(1'b1, 1'b1, exp_pix(i));
    pix_req = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_pix_valid", 32'(pix_valid), 0);
    chk("mid_rst_pix_data",  32'(pix_data), 0);
    chk("mid_rst_rd_req",    32'(bus.rd_req), 0);
    chk("mid_rst_rd_addr",   32'(bus.rd_addr), 0);
`ifdef FB_SCANOUT_STATS_EN
    chk("mid_rst_cnt",       32'(underflow_cnt), 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_rd_req", 32'(bus.rd_req), 0);
    end
    do_req(1'b0, 1'b1, 8'h00);
    pix_req = 1'b0;
    frame();
    idle(15);
    for (int i = 0; i < 4; i++) do_req(1'b1, 1'b1, exp_pix(i));
    idle(3);

    chk("sb_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
